// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin over fixed D-over-I priority.
package mem_bus_arbiter_pkg;

  localparam int MBUS_ADDR_W = 64;
  localparam int MBUS_DATA_W = 64;
  localparam int MBUS_STRB_W = MBUS_DATA_W / 8;

  // Instruction fetches are always 32-bit accesses
  localparam logic [2:0] MSIZE4 = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } grant_t;

  typedef struct packed {
    logic                   valid;
    logic [MBUS_ADDR_W-1:0] addr;
    logic [2:0]             size;
    logic [MBUS_STRB_W-1:0] strobe;
    logic [MBUS_DATA_W-1:0] data;
  } mbus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [MBUS_DATA_W-1:0] data;
  } mbus_resp_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_picker.sv
// Combinational winner select between the I and D requesters.
// With ARB_ROUND_ROBIN_EN defined, contention goes to whichever side was not granted last.
module arb_picker
  import mem_bus_arbiter_pkg::*;
(
  input  logic   i_instValid,
  input  logic   i_dataValid,
`ifdef ARB_ROUND_ROBIN_EN
  input  grant_t i_lastGrant,
`endif
  output grant_t o_winner
);

  always_comb begin
    o_winner = GNT_NONE;
    if (i_instValid && i_dataValid) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_winner = (i_lastGrant == GNT_D) ? GNT_I : GNT_D;
`else
      o_winner = GNT_D;
`endif
    end else if (i_dataValid) begin
      o_winner = GNT_D;
    end else if (i_instValid) begin
      o_winner = GNT_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/addr_ok/data_ok memory bus between instruction fetch (I) and load/store (D).
// Build macro ARB_ROUND_ROBIN_EN enables round-robin arbitration; default is fixed D-over-I.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = MBUS_ADDR_W,
  parameter int DATA_W = MBUS_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_data
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  grant_t     r_grant;
  grant_t     w_winner;
  mbus_req_t  r_req;
  mbus_resp_t w_mResp;
  logic       w_mValid;
  logic       w_addrOk;
  logic       w_dataOk;

  assign w_mResp = '{addr_ok: m_addr_ok, data_ok: m_data_ok, data: m_data};

`ifdef ARB_ROUND_ROBIN_EN
  grant_t r_lastGrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= GNT_I;
    end else if (r_state == ST_IDLE && w_winner != GNT_NONE) begin
      r_lastGrant <= w_winner;
    end
  end
`endif

  arb_picker u_picker (
    .i_instValid (i_valid),
    .i_dataValid (d_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .i_lastGrant (r_lastGrant),
`endif
    .o_winner    (w_winner)
  );

  // Requester fields are captured only at grant, so later changes on the ports are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= GNT_NONE;
      r_req   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE) begin
        r_grant <= w_winner;
        if (w_winner == GNT_D) begin
          r_req <= '{valid: 1'b1, addr: d_addr, size: d_size, strobe: d_strobe, data: d_wdata};
        end else if (w_winner == GNT_I) begin
          r_req <= '{valid: 1'b1, addr: i_addr, size: MSIZE4, strobe: '0, data: '0};
        end
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_mValid    = 1'b0;
    w_addrOk    = 1'b0;
    w_dataOk    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_winner != GNT_NONE) w_nextState = ST_ADDR;
      end
      ST_ADDR: begin
        w_mValid = r_req.valid;
        if (w_mResp.addr_ok) begin
          w_addrOk = 1'b1;
          if (w_mResp.data_ok) begin
            w_dataOk    = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_mResp.data_ok) begin
          w_dataOk    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Everything is forced quiet while rst is high so an aborted transaction emits no pulses
  assign m_valid   = w_mValid && !rst;
  assign m_addr    = m_valid ? r_req.addr   : '0;
  assign m_size    = m_valid ? r_req.size   : '0;
  assign m_strobe  = m_valid ? r_req.strobe : '0;
  assign m_wdata   = m_valid ? r_req.data   : '0;

  assign i_addr_ok = w_addrOk && (r_grant == GNT_I) && !rst;
  assign i_data_ok = w_dataOk && (r_grant == GNT_I) && !rst;
  assign d_addr_ok = w_addrOk && (r_grant == GNT_D) && !rst;
  assign d_data_ok = w_dataOk && (r_grant == GNT_D) && !rst;
  assign i_data    = i_data_ok ? w_mResp.data : '0;
  assign d_data    = d_data_ok ? w_mResp.data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the bench plays the memory side.
// Round-robin expectations apply when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [63:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [63:0] d_data;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [63:0] m_data;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_data(m_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance to 1ns after the next rising edge, where inputs are driven
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".m_valid"},   m_valid,   1'b0);
    checkOutput({tag, ".i_addr_ok"}, i_addr_ok, 1'b0);
    checkOutput({tag, ".i_data_ok"}, i_data_ok, 1'b0);
    checkOutput({tag, ".d_addr_ok"}, d_addr_ok, 1'b0);
    checkOutput({tag, ".d_data_ok"}, d_data_ok, 1'b0);
    checkOutput({tag, ".i_data"},    i_data,    64'h0);
    checkOutput({tag, ".d_data"},    d_data,    64'h0);
  endtask

  // Entered at drive time of the first ADDR cycle; returns in the following IDLE cycle.
  // dataLat == 0 means m_data_ok arrives together with m_addr_ok.
  task automatic memServe(input string tag, input logic isD, input logic [63:0] expAddr,
                          input logic [2:0] expSize, input logic [7:0] expStrobe,
                          input logic [63:0] expWdata, input int addrLat, input int dataLat,
                          input logic [63:0] rdata);
    logic gAddrOk, gDataOk, oAddrOk, oDataOk;
    logic [63:0] gData, oData;
    for (int c = 1; c <= addrLat; c++) begin
      m_addr_ok = (c == addrLat);
      m_data_ok = (c == addrLat) && (dataLat == 0);
      m_data    = m_data_ok ? rdata : 64'h0;
      #1;
      gAddrOk = isD ? d_addr_ok : i_addr_ok;  oAddrOk = isD ? i_addr_ok : d_addr_ok;
      gDataOk = isD ? d_data_ok : i_data_ok;  oDataOk = isD ? i_data_ok : d_data_ok;
      gData   = isD ? d_data : i_data;        oData   = isD ? i_data : d_data;
      checkOutput({tag, ".m_valid"},  m_valid,  1'b1);
      checkOutput({tag, ".m_addr"},   m_addr,   expAddr);
      checkOutput({tag, ".m_size"},   m_size,   expSize);
      checkOutput({tag, ".m_strobe"}, m_strobe, expStrobe);
      checkOutput({tag, ".m_wdata"},  m_wdata,  expWdata);
      checkOutput({tag, ".addr_ok"},  gAddrOk,  (c == addrLat));
      checkOutput({tag, ".other_addr_ok"}, oAddrOk, 1'b0);
      checkOutput({tag, ".data_ok_a"}, gDataOk, m_data_ok);
      checkOutput({tag, ".data_a"},    gData,   m_data_ok ? rdata : 64'h0);
      checkOutput({tag, ".other_data_ok_a"}, oDataOk, 1'b0);
      checkOutput({tag, ".other_data_a"}, oData, 64'h0);
      applyStimulus();
    end
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_data    = 64'h0;
    if (isD) d_valid = 1'b0; else i_valid = 1'b0;
    for (int c = 1; c <= dataLat; c++) begin
      m_data_ok = (c == dataLat);
      m_data    = m_data_ok ? rdata : 64'hFFFF_0000_FFFF_0000;
      #1;
      gDataOk = isD ? d_data_ok : i_data_ok;  oDataOk = isD ? i_data_ok : d_data_ok;
      gData   = isD ? d_data : i_data;        oData   = isD ? i_data : d_data;
      checkOutput({tag, ".m_valid_data"}, m_valid, 1'b0);
      checkOutput({tag, ".data_ok"}, gDataOk, (c == dataLat));
      checkOutput({tag, ".data"},    gData,   (c == dataLat) ? rdata : 64'h0);
      checkOutput({tag, ".other_data_ok"}, oDataOk, 1'b0);
      checkOutput({tag, ".other_data"},    oData,   64'h0);
      applyStimulus();
    end
    m_data_ok = 1'b0;
    m_data    = 64'h0;
    #1;
    checkQuiet({tag, ".idle"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_data = '0;
    applyStimulus();
    checkQuiet("reset");
    checkOutput("reset.m_addr", m_addr, 64'h0);
    applyStimulus();
    rst = 1'b0;

    // I-only fetch: addr_ok two cycles after valid, data_ok at +5
    i_valid = 1'b1; i_addr = 64'h0000_0000_8000_0000;
    #1;
    checkOutput("ifetch.arb_cycle_m_valid", m_valid, 1'b0);
    applyStimulus();
    memServe("ifetch", 1'b0, 64'h0000_0000_8000_0000, 3'b010, 8'h00, 64'h0, 2, 3, 64'h0000_0000_0000_0013);

    // D write
    applyStimulus();
    d_valid = 1'b1; d_addr = 64'h0000_0000_8000_1000; d_size = 3'b011;
    d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF_0000_0001;
    applyStimulus();
    memServe("dwrite", 1'b1, 64'h0000_0000_8000_1000, 3'b011, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1, 2, 64'h0);
    d_strobe = 8'h00; d_wdata = 64'h0;

    // Both valid together from a fresh reset: D first, then I
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    d_valid = 1'b1; d_addr = 64'h0000_0000_0000_4000; d_size = 3'b011;
    i_valid = 1'b1; i_addr = 64'h0000_0000_0000_5000;
    applyStimulus();
    memServe("both.d", 1'b1, 64'h0000_0000_0000_4000, 3'b011, 8'h00, 64'h0, 1, 1, 64'h0000_0000_0000_0044);
    applyStimulus();
    memServe("both.i", 1'b0, 64'h0000_0000_0000_5000, 3'b010, 8'h00, 64'h0, 1, 1, 64'h0000_0000_0000_0055);

    // Four rounds with both requesters continuously valid
    d_valid = 1'b1; i_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic expD;
`ifdef ARB_ROUND_ROBIN_EN
      expD = (r % 2 == 0);
`else
      expD = 1'b1;
`endif
      d_addr = 64'h1000 + 64'(r);
      i_addr = 64'h2000 + 64'(r);
      applyStimulus();
      memServe($sformatf("round%0d", r), expD, expD ? 64'h1000 + 64'(r) : 64'h2000 + 64'(r),
               expD ? 3'b011 : 3'b010, 8'h00, 64'h0, 1, 1, 64'h0000_0000_0000_0100 + 64'(r));
      d_valid = 1'b1; i_valid = 1'b1;
    end
    d_valid = 1'b0; i_valid = 1'b0;

    // addr_ok and data_ok in the same cycle
    applyStimulus();
    d_valid = 1'b1; d_addr = 64'h0000_0000_8000_3000; d_size = 3'b010;
    applyStimulus();
    memServe("same", 1'b1, 64'h0000_0000_8000_3000, 3'b010, 8'h00, 64'h0, 1, 0, 64'hCAFE_F00D_1234_5678);

    // Reset while in DATA, followed by stray responses
    applyStimulus();
    i_valid = 1'b1; i_addr = 64'h0000_0000_8000_0100;
    applyStimulus();
    m_addr_ok = 1'b1;
    #1;
    checkOutput("rstdata.addr_ok", i_addr_ok, 1'b1);
    applyStimulus();
    m_addr_ok = 1'b0; i_valid = 1'b0; rst = 1'b1;
    #1;
    checkQuiet("rstdata.inreset");
    applyStimulus();
    rst = 1'b0; m_data_ok = 1'b1; m_addr_ok = 1'b1; m_data = 64'h0000_0000_0000_00AA;
    #1;
    checkQuiet("rstdata.stray");
    applyStimulus();
    m_data_ok = 1'b0; m_addr_ok = 1'b0; m_data = 64'h0;
    i_valid = 1'b1; i_addr = 64'h0000_0000_8000_0200;
    #1;
    checkOutput("rstdata.arb_m_valid", m_valid, 1'b0);
    applyStimulus();
    memServe("afterrst", 1'b0, 64'h0000_0000_8000_0200, 3'b010, 8'h00, 64'h0, 1, 2, 64'h0000_0000_0000_0055);

    // Address change after grant must not reach the bus
    applyStimulus();
    d_valid = 1'b1; d_addr = 64'h0000_0000_8000_2000; d_size = 3'b011;
    applyStimulus();
    d_addr = 64'h0000_0000_0000_1234;
    memServe("hold", 1'b1, 64'h0000_0000_8000_2000, 3'b011, 8'h00, 64'h0, 3, 1, 64'h0000_0000_0000_0077);

    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
